// File: rtl/pc_pkg.sv
// Shared definitions for the PC next-state unit: PC source selector codes and trap FSM states.
package pc_pkg;

    localparam logic [1:0] PCSEL_ALU  = 2'b00;
    localparam logic [1:0] PCSEL_ALUR = 2'b01;
    localparam logic [1:0] PCSEL_JMP  = 2'b10;
    localparam logic [1:0] PCSEL_EPC  = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational PC target selection: ALU result, registered ALU result, jump address or EPC.
module pc_target_mux
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int JTGT_W = 26
) (
    input  logic [1:0]               pc_sel_i,
    input  logic [XLEN-JTGT_W-3:0]   pc_hi_i,
    input  logic [XLEN-1:0]          alu_out_i,
    input  logic [XLEN-1:0]          alu_out_r_i,
    input  logic [JTGT_W-1:0]        jtgt_i,
    input  logic [XLEN-1:0]          epc_i,
    output logic [XLEN-1:0]          target_o
);

    logic [XLEN-1:0] jaddr;

    // Jump keeps the current PC region and word-aligns the target field.
    assign jaddr = {pc_hi_i, jtgt_i, 2'b00};

    always_comb begin
        target_o = alu_out_i;
        case (pc_sel_i)
            PCSEL_ALU:  target_o = alu_out_i;
            PCSEL_ALUR: target_o = alu_out_r_i;
            PCSEL_JMP:  target_o = jaddr;
            PCSEL_EPC:  target_o = epc_i;
            default:    target_o = alu_out_i;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Registered program counter with branch/jump selection, misaligned-target trap, EPC capture and eret.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] EXC_VEC   = 32'h0000_0180,
    parameter int              JTGT_W    = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_sel,
    input  logic              pc_write,
    input  logic              pc_write_c,
    input  logic              br_ne,
    input  logic              alu_zero,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   alu_out_r,
    input  logic [JTGT_W-1:0] jtgt,
    input  logic              exc_req,
    input  logic              exc_ack,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   epc,
    output logic              exc_pending,
    output logic              addr_err
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            pend_q, pend_d;
    logic            aerr_q, aerr_d;

    logic [XLEN-1:0] target;
    logic            upd;
    logic            misaligned;

    pc_target_mux #(
        .XLEN   (XLEN),
        .JTGT_W (JTGT_W)
    ) u_target_mux (
        .pc_sel_i    (pc_sel),
        .pc_hi_i     (pc_q[XLEN-1:JTGT_W+2]),
        .alu_out_i   (alu_out),
        .alu_out_r_i (alu_out_r),
        .jtgt_i      (jtgt),
        .epc_i       (epc_q),
        .target_o    (target)
    );

    assign upd        = pc_write | (pc_write_c & (alu_zero ^ br_ne));
    assign misaligned = |target[1:0];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        pend_d  = pend_q;
        aerr_d  = aerr_q;
        case (state_q)
            ST_RUN: begin
                if (exc_req || (upd && misaligned)) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VEC;
                    pend_d  = 1'b1;
                    aerr_d  = ~exc_req;
                    state_d = ST_TRAP;
                end else if (upd) begin
                    pc_d = target;
                end
            end
            ST_TRAP: begin
                // Handler keeps running; a bad target re-enters the vector without touching EPC.
                if (upd) begin
                    pc_d = misaligned ? EXC_VEC : target;
                end
                if (exc_ack) begin
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            pend_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            pend_q  <= pend_d;
            aerr_q  <= aerr_d;
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign exc_pending = pend_q;
    assign addr_err    = aerr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: stimulus pushes model predictions, a monitor checks every edge.
module tb_pc_next_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_sel = 2'b00;
    logic        pc_write = 1'b0;
    logic        pc_write_c = 1'b0;
    logic        br_ne = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] alu_out_r = '0;
    logic [25:0] jtgt = '0;
    logic        exc_req = 1'b0;
    logic        exc_ack = 1'b0;
    logic [31:0] pc, epc;
    logic        exc_pending, addr_err;

    pc_next_unit #(
        .XLEN      (32),
        .RESET_VEC (RESET_VEC),
        .EXC_VEC   (EXC_VEC),
        .JTGT_W    (26)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel      (pc_sel),
        .pc_write    (pc_write),
        .pc_write_c  (pc_write_c),
        .br_ne       (br_ne),
        .alu_zero    (alu_zero),
        .alu_out     (alu_out),
        .alu_out_r   (alu_out_r),
        .jtgt        (jtgt),
        .exc_req     (exc_req),
        .exc_ack     (exc_ack),
        .pc          (pc),
        .epc         (epc),
        .exc_pending (exc_pending),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        aerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference state: what the programmer-visible unit should hold.
    logic [31:0] m_pc, m_epc;
    logic        m_pend, m_aerr, m_in_handler;

    task automatic model_step();
        logic [31:0] tgt;
        bit          take;
        if (rst) begin
            m_pc = RESET_VEC; m_epc = '0; m_pend = 0; m_aerr = 0; m_in_handler = 0;
            return;
        end
        case (pc_sel)
            2'd0: tgt = alu_out;
            2'd1: tgt = alu_out_r;
            2'd2: tgt = (m_pc & 32'hF000_0000) | (32'(jtgt) * 4);
            default: tgt = m_epc;
        endcase
        take = pc_write || (pc_write_c && (br_ne ? !alu_zero : alu_zero));
        if (!m_in_handler) begin
            if (exc_req || (take && (tgt % 4 != 0))) begin
                m_epc = m_pc; m_pc = EXC_VEC; m_pend = 1;
                m_aerr = !exc_req; m_in_handler = 1;
            end else if (take) begin
                m_pc = tgt;
            end
        end else begin
            if (take) m_pc = (tgt % 4 != 0) ? EXC_VEC : tgt;
            if (exc_ack) begin
                m_pend = 0; m_in_handler = 0;
            end
        end
    endtask

    // Apply current inputs for one clock: predict, enqueue, then settle past the edge.
    task automatic step();
        exp_t e;
        model_step();
        e.pc = m_pc; e.epc = m_epc; e.pend = m_pend; e.aerr = m_aerr;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        rst = 0; pc_sel = 2'b00; pc_write = 0; pc_write_c = 0; br_ne = 0; alu_zero = 0;
        exc_req = 0; exc_ack = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        idle_inputs(); pc_sel = 2'b00; pc_write = 1; alu_out = v;
        step();
        idle_inputs();
    endtask

    // Monitor: the unit presents a new state on every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            checks++;
            if (pc !== e.pc || epc !== e.epc || exc_pending !== e.pend || addr_err !== e.aerr) begin
                errors++;
                $display("FAIL txn%0d: got pc=%08h epc=%08h pend=%0b aerr=%0b expected pc=%08h epc=%08h pend=%0b aerr=%0b",
                         txn, pc, epc, exc_pending, addr_err, e.pc, e.epc, e.pend, e.aerr);
            end else begin
                $display("txn%0d ok pc=%08h epc=%08h pend=%0b aerr=%0b", txn, pc, epc, exc_pending, addr_err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then hold with no update
        idle_inputs(); rst = 1;
        step(); step();
        chk("rst_pc", pc, 32'h0); chk("rst_epc", epc, 32'h0);
        chk("rst_pend", 32'(exc_pending), 32'h0); chk("rst_aerr", 32'(addr_err), 32'h0);
        idle_inputs(); alu_out = 32'h44; step();
        chk("hold_no_upd", pc, 32'h0);

        // Unconditional ALUOut update
        idle_inputs(); pc_write = 1; alu_out = 32'h4; step();
        chk("alu_write", pc, 32'h4);
        idle_inputs(); step();
        chk("alu_hold", pc, 32'h4);

        // BEQ / BNE taken and not taken
        for (int ne = 0; ne < 2; ne++) begin
            for (int z = 1; z >= 0; z--) begin
                set_pc(32'h40);
                pc_sel = 2'b01; pc_write_c = 1; alu_out_r = 32'h100;
                br_ne = ne[0]; alu_zero = z[0];
                step();
                chk($sformatf("branch_ne%0d_z%0d", ne, z), pc, (z != ne) ? 32'h100 : 32'h40);
            end
        end

        // Jump keeps region bits
        set_pc(32'h9000_0010);
        pc_sel = 2'b10; jtgt = 26'h10; pc_write = 1; step();
        chk("jump", pc, 32'h9000_0040);

        // Misaligned target trap, then eret with ack
        set_pc(32'h20);
        pc_write = 1; alu_out = 32'h22; step();
        chk("mis_pc", pc, 32'h180); chk("mis_epc", epc, 32'h20);
        chk("mis_aerr", 32'(addr_err), 32'h1); chk("mis_pend", 32'(exc_pending), 32'h1);
        idle_inputs(); pc_sel = 2'b11; pc_write = 1; exc_ack = 1; step();
        chk("eret_pc", pc, 32'h20); chk("eret_pend", 32'(exc_pending), 32'h0);
        chk("eret_aerr_kept", 32'(addr_err), 32'h1);

        // Exception request beats update; second request in handler ignored; reset mid-trap
        set_pc(32'h8);
        exc_req = 1; pc_write = 1; alu_out = 32'h30; step();
        chk("exc_pc", pc, 32'h180); chk("exc_epc", epc, 32'h8);
        chk("exc_aerr", 32'(addr_err), 32'h0);
        idle_inputs(); exc_req = 1; step();
        chk("exc2_pc", pc, 32'h180); chk("exc2_epc", epc, 32'h8);
        idle_inputs(); rst = 1; step();
        chk("rst_trap_pc", pc, 32'h0); chk("rst_trap_pend", 32'(exc_pending), 32'h0);

        // Randomized traffic checked only by the scoreboard
        for (int i = 0; i < 300; i++) begin
            rst        = ($urandom_range(0, 49) == 0);
            pc_sel     = 2'($urandom_range(0, 3));
            pc_write   = ($urandom_range(0, 3) == 0);
            pc_write_c = 1'($urandom_range(0, 1));
            br_ne      = 1'($urandom_range(0, 1));
            alu_zero   = 1'($urandom_range(0, 1));
            alu_out    = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            alu_out_r  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            jtgt       = 26'($urandom);
            exc_req    = ($urandom_range(0, 19) == 0);
            exc_ack    = ($urandom_range(0, 5) == 0);
            step();
        end

        idle_inputs();
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
